// File: rtl/reg_file_wr_arb.sv
// rtl/reg_file_wr_arb.sv - round-robin write-port arbiter for reg_file; optional clear sequencer under REG_ARB_CLEAR_EN
module reg_file_wr_arb #(
  parameter int BITS  = 16,
  parameter int ADDR  = 4,
  parameter int DEPTH = 16,
  parameter int NREQ  = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*ADDR-1:0]   req_addr,
  input  logic [NREQ*BITS-1:0]   req_data,
  output logic [NREQ-1:0]        gnt,
  input  logic                   clr_req,
  output logic                   busy,
  output logic                   clr_done,
  output logic                   we,
  output logic [ADDR-1:0]        wa,
  output logic [BITS-1:0]        wd
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Registered write-port state; every output is a flop.
  logic [PW-1:0]   ptr_q,  ptr_d;
  logic [NREQ-1:0] gnt_q,  gnt_d;
  logic            we_q,   we_d;
  logic [ADDR-1:0] wa_q,   wa_d;
  logic [BITS-1:0] wd_q,   wd_d;

  // Arbitration result for the current cycle.
  logic [NREQ-1:0] elig;
  logic            win_found;
  logic [NREQ-1:0] win_oh;
  logic [PW-1:0]   win_next;
  logic [ADDR-1:0] win_addr;
  logic [BITS-1:0] win_data;
  logic [PW:0]     scan_sum;
  logic [PW-1:0]   scan_idx;
  logic            arb_en;

`ifdef REG_ARB_CLEAR_EN
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [ADDR-1:0] cnt_q,   cnt_d;
  logic            busy_q,  busy_d;
  logic            done_q,  done_d;

  assign busy     = busy_q;
  assign clr_done = done_q;
`else
  // Without the clear sequencer the command input has no effect.
  logic unused_clr_req;
  assign unused_clr_req = clr_req;
  assign busy           = 1'b0;
  assign clr_done       = 1'b0;
`endif

  assign gnt = gnt_q;
  assign we  = we_q;
  assign wa  = wa_q;
  assign wd  = wd_q;

  // Scan eligible requesters starting at ptr; last cycle's grantee is masked
  // so a requester dropping req on its grant edge is not granted again.
  always_comb begin
    elig      = req & ~gnt_q;
    win_found = 1'b0;
    win_oh    = '0;
    win_next  = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (scan_sum >= (PW+1)'(NREQ)) begin
        scan_sum = scan_sum - (PW+1)'(NREQ);
      end
      scan_idx = scan_sum[PW-1:0];
      if (!win_found && elig[scan_idx]) begin
        win_found        = 1'b1;
        win_oh[scan_idx] = 1'b1;
        win_next         = (scan_idx == PW'(NREQ-1)) ? '0 : scan_idx + 1'b1;
      end
    end
  end

  // Select the winner's address and data from the packed request buses.
  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_oh[i]) begin
        win_addr = req_addr[i*ADDR +: ADDR];
        win_data = req_data[i*BITS +: BITS];
      end
    end
  end

`ifdef REG_ARB_CLEAR_EN
  // Next state: a clear command beats any request at the same edge; the last
  // clear cycle hands back to IDLE and may grant in the same edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    we_d    = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    arb_en  = 1'b1;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          arb_en  = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          we_d    = 1'b1;
          wa_d    = '0;
          wd_d    = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == ADDR'(DEPTH-1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          arb_en  = 1'b0;
          cnt_d   = cnt_q + 1'b1;
          busy_d  = 1'b1;
          we_d    = 1'b1;
          wa_d    = cnt_q + 1'b1;
          wd_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        arb_en  = 1'b0;
      end
    endcase
    if (arb_en && win_found) begin
      gnt_d = win_oh;
      we_d  = 1'b1;
      wa_d  = win_addr;
      wd_d  = win_data;
      ptr_d = win_next;
    end
  end

  // Clear-sequencer state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
`else
  // Next state: plain arbitration every edge; wa/wd hold when nobody wins.
  always_comb begin
    ptr_d  = ptr_q;
    gnt_d  = '0;
    we_d   = 1'b0;
    wa_d   = wa_q;
    wd_d   = wd_q;
    arb_en = 1'b1;
    if (arb_en && win_found) begin
      gnt_d = win_oh;
      we_d  = 1'b1;
      wa_d  = win_addr;
      wd_d  = win_data;
      ptr_d = win_next;
    end
  end
`endif

  // Arbitration and write-port registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q <= '0;
      gnt_q <= '0;
      we_q  <= 1'b0;
      wa_q  <= '0;
      wd_q  <= '0;
    end else begin
      ptr_q <= ptr_d;
      gnt_q <= gnt_d;
      we_q  <= we_d;
      wa_q  <= wa_d;
      wd_q  <= wd_d;
    end
  end

endmodule

// File: tb/tb_reg_file_wr_arb.sv
// tb/tb_reg_file_wr_arb.sv - randomized self-checking bench for reg_file_wr_arb
module tb_reg_file_wr_arb;
  localparam int BITS  = 16;
  localparam int ADDR  = 4;
  localparam int DEPTH = 16;
  localparam int NREQ  = 4;
`ifdef REG_ARB_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [NREQ-1:0]      req;
  logic [NREQ*ADDR-1:0] req_addr;
  logic [NREQ*BITS-1:0] req_data;
  logic [NREQ-1:0]      gnt;
  logic                 clr_req;
  logic                 busy;
  logic                 clr_done;
  logic                 we;
  logic [ADDR-1:0]      wa;
  logic [BITS-1:0]      wd;

  int checks = 0;
  int errors = 0;

  reg_file_wr_arb #(.BITS(BITS), .ADDR(ADDR), .DEPTH(DEPTH), .NREQ(NREQ)) dut (
    .clk(clk), .rstn(rstn), .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt), .clr_req(clr_req), .busy(busy), .clr_done(clr_done),
    .we(we), .wa(wa), .wd(wd)
  );

  always #5 clk = ~clk;

  // Register-file image built from the write port.
  logic [BITS-1:0] mem [DEPTH];
  always @(posedge clk) if (we) mem[wa] <= wd;

  // Reference model state.
  int              m_ptr;
  int              m_cnt;
  logic [NREQ-1:0] m_gnt;
  logic            m_we, m_busy, m_done;
  logic [ADDR-1:0] m_wa;
  logic [BITS-1:0] m_wd;

  task automatic model_reset();
    m_ptr = 0; m_cnt = -1; m_gnt = '0; m_we = 0; m_busy = 0; m_done = 0;
    m_wa = '0; m_wd = '0;
  endtask

  task automatic model_edge();
    logic [NREQ-1:0] elig;
    int w;
    m_done = 0;
    if (m_cnt >= 0) begin
      if (m_cnt == DEPTH-1) begin
        m_cnt = -1; m_done = 1;
      end else begin
        m_cnt++; m_wa = ADDR'(m_cnt); m_wd = '0; m_we = 1; m_gnt = '0; m_busy = 1;
        return;
      end
    end else if (CLR_EN && clr_req) begin
      m_cnt = 0; m_wa = '0; m_wd = '0; m_we = 1; m_gnt = '0; m_busy = 1;
      return;
    end
    m_busy = 0;
    elig = req & ~m_gnt;
    w = -1;
    for (int k = 0; k < NREQ; k++) begin
      if (w < 0 && elig[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
    end
    if (w >= 0) begin
      m_gnt = '0; m_gnt[w] = 1'b1; m_we = 1;
      m_wa = req_addr[w*ADDR +: ADDR];
      m_wd = req_data[w*BITS +: BITS];
      m_ptr = (w + 1) % NREQ;
    end else begin
      m_gnt = '0; m_we = 0;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [ADDR-1:0] a, input logic [BITS-1:0] d);
    req_addr[i*ADDR +: ADDR] = a;
    req_data[i*BITS +: BITS] = d;
  endtask

  task automatic do_reset();
    rstn = 0; req = '0; clr_req = 0; req_addr = '0; req_data = '0;
    @(posedge clk); #1;
    model_reset();
    rstn = 1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, ADDR'(i + 3), BITS'(16'h5500 + i));
    req = 4'b1111;
    step(); step();
    rstn = 0;
    #2;
    checks++; if (gnt !== '0) begin errors++; $display("FAIL reset_gnt got %b want 0", gnt); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", we); end
    checks++; if (wa !== '0) begin errors++; $display("FAIL reset_wa got %h want 0", wa); end
    checks++; if (wd !== '0) begin errors++; $display("FAIL reset_wd got %h want 0", wd); end
    checks++; if (busy !== 1'b0 || clr_done !== 1'b0) begin
      errors++; $display("FAIL reset_busy_done got %b%b want 00", busy, clr_done);
    end
    model_reset();
    req = 4'b1010;
    rstn = 1;
    step();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL reset_first_grant got %b want 0010", gnt); end
    checks++; if (wa !== 4'd4 || wd !== 16'h5501) begin
      errors++; $display("FAIL reset_first_write got %h/%h want 4/5501", wa, wd);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, ADDR'(i), BITS'(16'hA000 + i));
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin
      step();
      checks++; if (gnt !== 4'(1 << i) || we !== 1'b1) begin
        errors++; $display("FAIL rr_gnt%0d got %b we %b want %b we 1", i, gnt, we, 4'(1 << i));
      end
      checks++; if (wa !== ADDR'(i) || wd !== BITS'(16'hA000 + i)) begin
        errors++; $display("FAIL rr_write%0d got %h/%h want %h/%h", i, wa, wd, i, 16'hA000 + i);
      end
      req[i] = 1'b0;
    end
    step();
    checks++; if (gnt !== '0 || we !== 1'b0 || wa !== 4'd3 || wd !== 16'hA003) begin
      errors++; $display("FAIL rr_idle_hold got %b %b %h %h want 0000 0 3 a003", gnt, we, wa, wd);
    end
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] prev;
    do_reset();
    set_req(0, 4'h1, 16'h1111);
    set_req(2, 4'h2, 16'h2222);
    req = 4'b0101;
    prev = '0;
    for (int c = 0; c < 8; c++) begin
      step();
      checks++; if (gnt !== ((c % 2 == 0) ? 4'b0001 : 4'b0100) || gnt === prev) begin
        errors++; $display("FAIL fair_c%0d got %b prev %b want %b", c, gnt, prev,
                           (c % 2 == 0) ? 4'b0001 : 4'b0100);
      end
      checks++; if (wa !== m_wa || wd !== m_wd) begin
        errors++; $display("FAIL fair_write_c%0d got %h/%h want %h/%h", c, wa, wd, m_wa, m_wd);
      end
      prev = gnt;
      for (int i = 0; i < NREQ; i++) if (m_gnt[i]) set_req(i, ADDR'($urandom), BITS'($urandom));
    end
  endtask

  task automatic test_single();
    do_reset();
    set_req(1, ADDR'($urandom), BITS'($urandom));
    req = 4'b0010;
    for (int c = 0; c < 8; c++) begin
      step();
      checks++; if (we !== (c % 2 == 0) || gnt !== ((c % 2 == 0) ? 4'b0010 : 4'b0000)) begin
        errors++; $display("FAIL single_c%0d got we %b gnt %b want we %0d", c, we, gnt, (c % 2 == 0));
      end
      checks++; if (wa !== m_wa || wd !== m_wd) begin
        errors++; $display("FAIL single_write_c%0d got %h/%h want %h/%h", c, wa, wd, m_wa, m_wd);
      end
      if (m_gnt[1]) set_req(1, ADDR'($urandom), BITS'($urandom));
    end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] pend;
    do_reset();
    pend = '0;
    for (int c = 0; c < 300; c++) begin
      req = pend;
      step();
      checks++; if (gnt !== m_gnt || we !== m_we || wa !== m_wa || wd !== m_wd) begin
        errors++; $display("FAIL random_c%0d got %b %b %h %h want %b %b %h %h",
                           c, gnt, we, wa, wd, m_gnt, m_we, m_wa, m_wd);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (m_gnt[i]) pend[i] = 1'b0;
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          set_req(i, ADDR'($urandom), BITS'($urandom));
        end
      end
    end
    req = '0;
  endtask

`ifdef REG_ARB_CLEAR_EN
  task automatic test_clear();
    do_reset();
    for (int a = 0; a < DEPTH; a++) begin
      set_req(0, ADDR'(a), BITS'(16'hC000 + a));
      req = 4'b0001;
      step();
      req = '0;
      step();
    end
    set_req(3, 4'h5, 16'h1234);
    req = 4'b1000;
    clr_req = 1;
    step();
    clr_req = 0;
    for (int k = 0; k < DEPTH; k++) begin
      if (k > 0) step();
      checks++; if (busy !== 1'b1 || we !== 1'b1 || wa !== ADDR'(k) || wd !== '0 || gnt !== '0) begin
        errors++; $display("FAIL clear_k%0d got busy %b we %b wa %h wd %h gnt %b want 1 1 %h 0 0",
                           k, busy, we, wa, wd, gnt, k);
      end
      clr_req = (k == 4);
    end
    clr_req = 0;
    step();
    checks++; if (clr_done !== 1'b1 || busy !== 1'b0 || gnt !== 4'b1000) begin
      errors++; $display("FAIL clear_exit got done %b busy %b gnt %b want 1 0 1000", clr_done, busy, gnt);
    end
    checks++; if (we !== 1'b1 || wa !== 4'h5 || wd !== 16'h1234) begin
      errors++; $display("FAIL clear_exit_write got %b %h %h want 1 5 1234", we, wa, wd);
    end
    for (int a = 0; a < DEPTH; a++) begin
      checks++; if (mem[a] !== '0) begin errors++; $display("FAIL clear_readback%0d got %h want 0", a, mem[a]); end
    end
    req = '0;
    step();
    checks++; if (clr_done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL clear_done_pulse got %b %b want 0 0", clr_done, busy);
    end
  endtask

  task automatic test_reset_mid_clear();
    do_reset();
    clr_req = 1;
    step();
    clr_req = 0;
    for (int k = 0; k < 7; k++) step();
    checks++; if (wa !== 4'd7 || wa !== m_wa) begin errors++; $display("FAIL midclr_wa got %h want 7", wa); end
    rstn = 0;
    #2;
    checks++; if (busy !== 1'b0 || we !== 1'b0 || wa !== '0) begin
      errors++; $display("FAIL midclr_reset got busy %b we %b wa %h want 0 0 0", busy, we, wa);
    end
    model_reset();
    rstn = 1;
    step();
    checks++; if (busy !== 1'b0 || we !== 1'b0) begin
      errors++; $display("FAIL midclr_no_resume got busy %b we %b want 0 0", busy, we);
    end
    clr_req = 1;
    step();
    clr_req = 0;
    checks++; if (busy !== 1'b1 || we !== 1'b1 || wa !== '0) begin
      errors++; $display("FAIL midclr_restart got busy %b we %b wa %h want 1 1 0", busy, we, wa);
    end
    for (int k = 0; k < DEPTH; k++) begin
      step();
      checks++; if (busy !== m_busy || clr_done !== m_done || we !== m_we || wa !== m_wa) begin
        errors++; $display("FAIL midclr_seq%0d got %b %b %b %h want %b %b %b %h",
                           k, busy, clr_done, we, wa, m_busy, m_done, m_we, m_wa);
      end
    end
  endtask
`else
  task automatic test_clr_ignored();
    do_reset();
    set_req(3, 4'h9, 16'hBEEF);
    req = 4'b1000;
    clr_req = 1;
    step();
    clr_req = 0;
    req = '0;
    checks++; if (gnt !== 4'b1000 || wa !== 4'h9 || wd !== 16'hBEEF) begin
      errors++; $display("FAIL clr_ignored_gnt got %b %h %h want 1000 9 beef", gnt, wa, wd);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (busy !== 1'b0 || clr_done !== 1'b0 || we !== 1'b0) begin
        errors++; $display("FAIL clr_ignored_k%0d got %b %b %b want 0 0 0", k, busy, clr_done, we);
      end
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_fairness();
    test_single();
    test_random();
`ifdef REG_ARB_CLEAR_EN
    test_clear();
    test_reset_mid_clear();
`else
    test_clr_ignored();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_file_wr_arb.md
# reg_file_wr_arb

Round-robin arbiter and sequencer for the single write port of the `reg_file` register file. Shares the write port among `NREQ` requesters with a req/gnt handshake and fair rotating priority, and drives the register file's `WE`/`WA`/`WD` from registers. An optional clear sequencer walks every address and writes zero on command.

## Interface
- `BITS`, 16: data width; matches `reg_file` `BITS`.
- `ADDR`, 4: address width; matches `reg_file` `ADDR`.
- `DEPTH`, 16: number of entries; `DEPTH <= 2**ADDR`.
- `NREQ`, 4: number of requesters; `2..16`.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `req`  in  `NREQ`  per-requester write request; held high until granted.
- `req_addr`  in  `NREQ*ADDR`  packed addresses; requester i uses bits `[i*ADDR +: ADDR]`.
- `req_data`  in  `NREQ*BITS`  packed data; requester i uses bits `[i*BITS +: BITS]`.
- `gnt`  out  `NREQ`  one-hot grant, registered, high for exactly one cycle per accepted write.
- `clr_req`  in  1  single-cycle clear command.
- `busy`  out  1  clear sequence in progress.
- `clr_done`  out  1  one-cycle pulse when the clear completes.
- `we`, `wa`, `wd`  out  `1`/`ADDR`/`BITS`  registered outputs to `reg_file` `WE`/`WA`/`WD`.

## Operation
- States: `IDLE` and `CLEAR`. Arbitration runs in `IDLE` only.
- Reset: all outputs 0. State is `IDLE`. Priority pointer `ptr` is 0. Clear counter is 0.
- Arbitration happens at each edge in `IDLE`.
  - The eligible set is `req & ~gnt`. A requester granted in the current cycle is masked, so a requester dropping `req` on the grant edge is never granted twice.
  - The winner is the first eligible index scanning `ptr, ptr+1, …, NREQ-1, 0, …` (mod `NREQ`).
  - On a win by requester w:
    - `gnt[w]` is 1 and all other `gnt` bits are 0.
    - `we=1`, `wa=req_addr[w]`, `wd=req_data[w]`.
    - `ptr <= (w+1) mod NREQ`.
  - With no eligible requester: `gnt=0`, `we=0`, and `wa`/`wd` hold their previous values. `ptr` is unchanged.
- Handshake:
  - A requester keeps `req`, address and data stable until it sees its `gnt` bit high.
  - It may deassert `req` or present a new write at the following edge.
- Clear (only with `REG_ARB_CLEAR_EN`):
  - When `clr_req` is sampled high in `IDLE`, the block enters `CLEAR`. `clr_req` takes priority over any `req` sampled at the same edge; no grant is issued at that edge.
  - `CLEAR` issues one write per cycle: `we=1`, `wd=0`, `wa` = 0, 1, …, `DEPTH-1`. `busy=1` and `gnt=0` throughout.
  - After the `DEPTH-1` write the block returns to `IDLE`, with `clr_done=1` for one cycle.
  - `clr_req` while `busy` is ignored.
  - `ptr` is unchanged by a clear.
- Reset asserted mid-clear or mid-grant returns everything to reset values immediately. No partial clear resumes.
- `req_addr` values `>= DEPTH` are passed through unchecked; guarding them is the requester's responsibility.

## Timing
- Grant latency: `req` sampled high at edge N (no clear pending) gives `gnt`/`we`/`wa`/`wd` valid in the cycle after edge N.
- `reg_file` captures the write at edge N+1.
- Throughput:
  - One write per cycle aggregate when 2 or more requesters are active.
  - One write every 2 cycles for a single active requester, because of grant masking.
- Clear, with `clr_req` sampled at edge N:
  - `busy=1`, `we=1`, `wa=0` after edge N.
  - `wa=DEPTH-1` after edge N+DEPTH-1.
  - After edge N+DEPTH: `busy=0`, `clr_done=1`. A grant may be issued in that same cycle for requests sampled at edge N+DEPTH.
  - The clear occupies `DEPTH` write cycles in total.
- All outputs are flop outputs; there is no combinational path from inputs to outputs.

## Configuration
- Macro `REG_ARB_CLEAR_EN`.
- Defined: the `CLEAR` state, clear counter, `busy` and `clr_done` are present, with behaviour as above.
- Undefined:
  - Only `IDLE` arbitration is built and `clr_req` is ignored.
  - `busy` and `clr_done` are tied to 0.
  - Arbitration behaviour is otherwise identical.

## Test plan
- **Reset values:** `rstn=0` mid-run → `gnt=0`, `we=0`, `wa=0`, `wd=0`, `busy=0`, `clr_done=0` without waiting for a clock edge. First grant after release goes to the lowest requesting index.
- **Round-robin:** `NREQ=4`, `req=4'b1111` held, each requester drops its `req` after its grant → grants in order 0,1,2,3, one per cycle. `wa`/`wd` match each requester's inputs (e.g. addr i, data `16'hA000+i`).
- **Fairness with a re-requester:** `req[0]` and `req[2]` held high continuously → grants alternate 0,2,0,2. Never two consecutive grants to the same index.
- **Single requester:** only `req[1]`, which re-asserts immediately with a new address → `gnt[1]` high every other cycle and `we` toggles 1,0,1,0.
- **Clear (macro on):** `clr_req` pulse with `req[3]` high at the same edge → 16 cycles of `we=1`, `wd=0`, `wa=0..15`, `busy=1`, `gnt=0`. Then `clr_done=1` and `gnt[3]` in the same cycle. A readback of all 16 entries via `RE1` returns 0.
- **Reset mid-clear (macro on):** `rstn` pulsed low at `wa=7` → `busy=0`, `we=0` and state `IDLE`. The next `clr_req` restarts from `wa=0`.
